asic_poc_seq: RTL and testbench

- Power-on-control sequencer for the sky130 pad ring.
- Drives the shared `poc` net consumed by the IO supply pads, plus IO output enable, core reset and a ready flag.
- Qualifies the supply-good indication from the analog detector, holds the pad ring in its safe state for a fixed time, releases the IOs, then releases core reset.
- Also supports a sleep/wake handshake and power-loss recovery.

---
 rtl/asic_poc_seq.sv | 86 ++++++++
 tb/tb_asic_poc_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/asic_poc_seq.sv
// asic_poc_seq: power-on-control sequencer for the pad ring (poc, io enable, core reset, sleep/wake, power-loss recovery)
module asic_poc_seq #(
   parameter int SYNC_STAGES   = 2,
   parameter int DEBOUNCE      = 16,
   parameter int POC_CYCLES    = 64,
   parameter int SETTLE_CYCLES = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic pwr_good,
   input  logic sleep_req,
   input  logic pg_lost_clr,
   output logic poc,
   output logic io_en,
   output logic core_rst,
   output logic ready,
   output logic sleep_ack,
   output logic pg_lost
);
   typedef enum logic [2:0] {WAIT_PG, POC_HOLD, IO_SETTLE, RUN, QUIESCE, SLEEP} state_t;
   localparam logic [15:0] DB_T  = 16'(DEBOUNCE - 1);
   localparam logic [15:0] POC_T = 16'(POC_CYCLES - 1);
   localparam logic [15:0] SET_T = 16'(SETTLE_CYCLES - 1);
   state_t state, nxt;
   logic [15:0] cnt, nxt_cnt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic pg_s, lost;
   assign pg_s = sync_q[SYNC_STAGES-1];
   assign lost = (state != WAIT_PG) && !pg_s;
   // (poc, io_en, core_rst, ready, sleep_ack) for a given state
   function automatic logic [4:0] enc(input state_t s);
      return (s == IO_SETTLE || s == QUIESCE) ? 5'b01100 :
             (s == RUN)                        ? 5'b01010 :
             (s == SLEEP)                      ? 5'b10101 : 5'b10100;
   endfunction
   // pwr_good synchronizer chain
   always_ff @(posedge clk)
      sync_q <= rst ? '0 : {sync_q[SYNC_STAGES-2:0], pwr_good};
   // next state and shared counter; power loss overrides everything
   always_comb begin
      nxt     = state;
      nxt_cnt = cnt + 16'd1;
      case (state)
         WAIT_PG: begin
            nxt_cnt = pg_s ? cnt + 16'd1 : '0;
            if (pg_s && cnt == DB_T) begin
               nxt     = POC_HOLD;
               nxt_cnt = '0;
            end
         end
         POC_HOLD:  if (cnt == POC_T) begin nxt = IO_SETTLE; nxt_cnt = '0; end
         IO_SETTLE: if (cnt == SET_T) begin nxt = RUN;       nxt_cnt = '0; end
         RUN: begin
            nxt_cnt = '0;
            if (sleep_req) nxt = QUIESCE;
         end
         QUIESCE:   if (cnt == SET_T) begin nxt = SLEEP;     nxt_cnt = '0; end
         SLEEP: begin
            nxt_cnt = '0;
            if (!sleep_req) nxt = POC_HOLD;
         end
         default: begin
            nxt     = WAIT_PG;
            nxt_cnt = '0;
         end
      endcase
      if (lost) begin
         nxt     = WAIT_PG;
         nxt_cnt = '0;
      end
   end
   // state, counter and outputs registered together so outputs track state with no lag
   always_ff @(posedge clk) begin
      if (rst) begin
         state                                    <= WAIT_PG;
         cnt                                      <= '0;
         {poc, io_en, core_rst, ready, sleep_ack} <= 5'b10100;
         pg_lost                                  <= 1'b0;
      end else begin
         state                                    <= nxt;
         cnt                                      <= nxt_cnt;
         {poc, io_en, core_rst, ready, sleep_ack} <= enc(nxt);
         pg_lost                                  <= lost ? 1'b1 : pg_lost_clr ? 1'b0 : pg_lost;
      end
   end
endmodule

// File: tb/tb_asic_poc_seq.sv
// tb_asic_poc_seq: directed bench with a duration-based behavioural model and hand-pinned expectations
module tb_asic_poc_seq;
   localparam int DB = 4, PC = 8, SC = 4;
   logic clk = 0, rst = 1, pwr_good = 0, sleep_req = 0, pg_lost_clr = 0;
   logic poc, io_en, core_rst, ready, sleep_ack, pg_lost;
   int compared = 0, mismatched = 0, cyc = 0;
   int phase = 0, age = 0;
   bit lost = 0;
   bit pq[$] = '{0, 0};
   logic [4:0] tbl [6] = '{5'b10100, 5'b10100, 5'b01100, 5'b01010, 5'b01100, 5'b10101};

   asic_poc_seq #(.SYNC_STAGES(2), .DEBOUNCE(DB), .POC_CYCLES(PC), .SETTLE_CYCLES(SC)) dut (
      .clk(clk), .rst(rst), .pwr_good(pwr_good), .sleep_req(sleep_req), .pg_lost_clr(pg_lost_clr),
      .poc(poc), .io_en(io_en), .core_rst(core_rst), .ready(ready), .sleep_ack(sleep_ack), .pg_lost(pg_lost));

   always #5 clk = ~clk;

   // phases: 0 wait, 1 poc hold, 2 io settle, 3 run, 4 quiesce, 5 sleep; age = edges spent in phase
   task automatic model_step();
      bit ps;
      if (rst) begin
         phase = 0; age = 0; lost = 0; pq = '{0, 0};
         return;
      end
      ps = pq.pop_front();
      pq.push_back(pwr_good);
      if (phase != 0 && !ps) begin
         phase = 0; age = 0; lost = 1;
         return;
      end
      if (pg_lost_clr) lost = 0;
      age++;
      case (phase)
         0: begin
            if (!ps) age = 0;
            if (age == DB) begin phase = 1; age = 0; end
         end
         1: if (age == PC) begin phase = 2; age = 0; end
         2: if (age == SC) begin phase = 3; age = 0; end
         3: if (sleep_req) begin phase = 4; age = 0; end
         4: if (age == SC) begin phase = 5; age = 0; end
         default: if (!sleep_req) begin phase = 1; age = 0; end
      endcase
   endtask

   task automatic tick();
      logic [5:0] got, exp;
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      got = {poc, io_en, core_rst, ready, sleep_ack, pg_lost};
      exp = {tbl[phase], lost};
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL model tick %0d: got {poc,io_en,core_rst,ready,ack,lost}=%b expected %b", cyc, got, exp);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pin(input string nm, input logic got, input logic exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %b expected %b", nm, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      ticks(3);
      pin("rst_poc", poc, 1); pin("rst_io_en", io_en, 0); pin("rst_core_rst", core_rst, 1);
      pin("rst_ready", ready, 0); pin("rst_pg_lost", pg_lost, 0);
      // power-up: edge 0 is the next edge
      pwr_good = 1; rst = 0;
      ticks(5);
      pin("pu_wait_poc", poc, 1);
      ticks(8);
      pin("pu_hold_io_en", io_en, 0); pin("pu_hold_poc", poc, 1);
      ticks(1);
      pin("pu_settle_poc", poc, 0); pin("pu_settle_io_en", io_en, 1); pin("pu_settle_core_rst", core_rst, 1);
      ticks(3);
      pin("pu_settle_end_core_rst", core_rst, 1);
      ticks(1);
      pin("pu_run_core_rst", core_rst, 0); pin("pu_run_ready", ready, 1); pin("pu_pg_lost", pg_lost, 0);
      ticks(3);
      // sleep and wake
      sleep_req = 1;
      ticks(1);
      pin("sl_quiesce_core_rst", core_rst, 1); pin("sl_quiesce_io_en", io_en, 1); pin("sl_quiesce_ready", ready, 0);
      ticks(3);
      pin("sl_quiesce_ack", sleep_ack, 0);
      ticks(1);
      pin("sl_sleep_ack", sleep_ack, 1); pin("sl_sleep_poc", poc, 1); pin("sl_sleep_io_en", io_en, 0);
      ticks(3);
      sleep_req = 0;
      ticks(1);
      pin("wk_hold_ack", sleep_ack, 0); pin("wk_hold_poc", poc, 1);
      ticks(11);
      pin("wk_settle_ready", ready, 0);
      ticks(1);
      pin("wk_run_ready", ready, 1);
      // sleep_req dropped during quiesce still completes to sleep
      sleep_req = 1;
      ticks(2);
      sleep_req = 0;
      ticks(3);
      pin("sl_early_drop_ack", sleep_ack, 1);
      ticks(1);
      pin("sl_early_wake_ack", sleep_ack, 0);
      ticks(12);
      pin("sl_early_run_ready", ready, 1);
      // power loss in run
      pwr_good = 0;
      ticks(2);
      pin("pl_still_run", ready, 1);
      ticks(1);
      pin("pl_ready", ready, 0); pin("pl_poc", poc, 1); pin("pl_io_en", io_en, 0);
      pin("pl_core_rst", core_rst, 1); pin("pl_pg_lost", pg_lost, 1);
      pg_lost_clr = 1;
      ticks(1);
      pg_lost_clr = 0;
      pin("pl_clr", pg_lost, 0);
      ticks(3);
      pwr_good = 1;
      ticks(13);
      pin("pl_rep_io_en_before", io_en, 0);
      ticks(1);
      pin("pl_rep_io_en", io_en, 1);
      ticks(4);
      pin("pl_rep_ready", ready, 1);
      // loss coincident with sleep request and flag clear
      pwr_good = 0;
      ticks(2);
      sleep_req = 1; pg_lost_clr = 1;
      ticks(1);
      pin("sim_not_quiesce", io_en, 0); pin("sim_poc", poc, 1); pin("sim_set_wins", pg_lost, 1);
      ticks(1);
      pin("sim_clr_after", pg_lost, 0);
      pg_lost_clr = 0;
      ticks(2);
      // glitch shorter than debounce, sleep_req still high and ignored
      pwr_good = 1;
      ticks(3);
      pwr_good = 0;
      ticks(6);
      pin("gl_poc", poc, 1); pin("gl_pg_lost", pg_lost, 0);
      pwr_good = 1;
      ticks(13);
      pin("gl_io_en_before", io_en, 0);
      sleep_req = 0;
      ticks(1);
      pin("gl_io_en", io_en, 1);
      ticks(4);
      pin("gl_ready", ready, 1);
      // reset during io settle clears a set pg_lost
      pwr_good = 0;
      ticks(3);
      pwr_good = 1;
      ticks(15);
      pin("rm_settle_io_en", io_en, 1); pin("rm_lost_set", pg_lost, 1);
      rst = 1;
      ticks(1);
      pin("rm_pg_lost", pg_lost, 0); pin("rm_poc", poc, 1); pin("rm_io_en", io_en, 0);
      pin("rm_core_rst", core_rst, 1); pin("rm_ready", ready, 0);
      rst = 0;
      ticks(13);
      pin("rm_rep_io_en_before", io_en, 0);
      ticks(1);
      pin("rm_rep_io_en", io_en, 1);
      ticks(4);
      pin("rm_rep_ready", ready, 1);
      ticks(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
